// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use stall, branch flush, memory-wait freeze.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          R0_ZERO     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rs1D,
  input  logic [3:0] rs2D,
  input  logic [3:0] rs1E,
  input  logic [3:0] rs2E,
  input  logic [3:0] RdE,
  input  logic       regWriteE,
  input  logic [1:0] resultSrcE,
  input  logic [3:0] RdM,
  input  logic       regWriteM,
  input  logic [3:0] RdestW,
  input  logic       regWriteWB,
  input  logic       pcSrcE,
  input  logic       memReqM,
  input  logic       memAckM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       memErr
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] perfStallCnt,
  output logic [15:0] perfFlushCnt
`endif
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] SRC_LOAD    = 2'b01;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic       w_m_fwd_ok;
  logic       w_w_fwd_ok;
  logic       w_load_use;
  logic       w_mem_miss;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_d;
  logic       w_flush_e;

  // A producer targeting r0 never forwards or hazards when r0 is hard-wired.
  assign w_m_fwd_ok = regWriteM  && !(R0_ZERO && (RdM    == 4'd0));
  assign w_w_fwd_ok = regWriteWB && !(R0_ZERO && (RdestW == 4'd0));

  assign w_load_use = regWriteE && (resultSrcE == SRC_LOAD) &&
                      ((RdE == rs1D) || (RdE == rs2D)) &&
                      !(R0_ZERO && (RdE == 4'd0));

  assign w_mem_miss = memReqM && !memAckM;

  // The memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_m_fwd_ok && (RdM == rs1E))         w_fwd_a = FWD_MEM;
    else if (w_w_fwd_ok && (RdestW == rs1E)) w_fwd_a = FWD_WB;
    if (w_m_fwd_ok && (RdM == rs2E))         w_fwd_b = FWD_MEM;
    else if (w_w_fwd_ok && (RdestW == rs2E)) w_fwd_b = FWD_WB;
  end

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_stall_e = 1'b1;
          w_stall_m = 1'b1;
        end else begin
          if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
          // A taken branch discards the decode slot, so it beats the decode hold.
          if (pcSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_stall_d = 1'b0;
          end
        end
      end
      ST_MEM_WAIT: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every control output low at once, independent of the clock.
  assign stallF    = rst & w_stall_f;
  assign stallD    = rst & w_stall_d;
  assign stallE    = rst & w_stall_e;
  assign stallM    = rst & w_stall_m;
  assign flushD    = rst & w_flush_d;
  assign flushE    = rst & w_flush_e;
  assign forwardAE = rst ? w_fwd_a : FWD_RF;
  assign forwardBE = rst ? w_fwd_b : FWD_RF;
  assign memErr    = r_mem_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_miss) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (memAckM) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == TIMEOUT_CNT) begin
            r_mem_err  <= 1'b1;
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= 16'd0;
      r_perf_flush <= 16'd0;
    end else begin
      if (stallF && (r_perf_stall != 16'hFFFF)) r_perf_stall <= r_perf_stall + 16'd1;
      if (flushE && (r_perf_flush != 16'hFFFF)) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perfStallCnt = r_perf_stall;
  assign perfFlushCnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then randomized traffic against a cycle model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TO = 4;
  localparam bit R0Z    = 1'b1;

  typedef struct packed {
    logic       rst;
    logic [3:0] rs1D;
    logic [3:0] rs2D;
    logic [3:0] rs1E;
    logic [3:0] rs2E;
    logic [3:0] RdE;
    logic       regWriteE;
    logic [1:0] resultSrcE;
    logic [3:0] RdM;
    logic       regWriteM;
    logic [3:0] RdestW;
    logic       regWriteWB;
    logic       pcSrcE;
    logic       memReqM;
    logic       memAckM;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, RdE = '0, RdM = '0, RdestW = '0;
  logic       regWriteE = 1'b0, regWriteM = 1'b0, regWriteWB = 1'b0;
  logic [1:0] resultSrcE = '0;
  logic       pcSrcE = 1'b0, memReqM = 1'b0, memAckM = 1'b0;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, memErr;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] perfStallCnt, perfFlushCnt;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TO), .R0_ZERO(R0Z)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .RdE(RdE), .regWriteE(regWriteE), .resultSrcE(resultSrcE),
    .RdM(RdM), .regWriteM(regWriteM), .RdestW(RdestW), .regWriteWB(regWriteWB),
    .pcSrcE(pcSrcE), .memReqM(memReqM), .memAckM(memAckM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memErr(memErr)
`ifdef HAZ_PERF_CNT_EN
    , .perfStallCnt(perfStallCnt), .perfFlushCnt(perfFlushCnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  // Reference model state: cycles spent waiting on memory (0 = running) and the sticky error.
  int m_wait = 0;
  bit m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input stim_t s, input logic [3:0] rs);
    if (s.regWriteM && s.RdM == rs && !(R0Z && s.RdM == 0))               return 2'b10;
    else if (s.regWriteWB && s.RdestW == rs && !(R0Z && s.RdestW == 0))   return 2'b01;
    return 2'b00;
  endfunction

  // Expected vector: {memErr, stallF, stallD, stallE, stallM, flushD, flushE, fwdA, fwdB}
  task automatic model_step(input stim_t s, output logic [10:0] e);
    bit sf, sd, se, sm, fd, fe, lu, err_now;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0;
    if (!s.rst) begin
      m_wait = 0;
      m_err  = 1'b0;
      e      = '0;
      return;
    end
    lu = s.regWriteE && s.resultSrcE == 2'b01 && (s.RdE == s.rs1D || s.RdE == s.rs2D) &&
         !(R0Z && s.RdE == 0);
    err_now = m_err;
    if (m_wait > 0) begin
      {sf, sd, se, sm} = 4'b1111;
      if (s.memAckM) m_wait = 0;
      else if (m_wait == MEM_TO) begin m_err = 1'b1; m_wait = 0; end
      else m_wait = m_wait + 1;
    end else if (s.memReqM && !s.memAckM) begin
      {sf, sd, se, sm} = 4'b1111;
      m_wait = 1;
    end else begin
      sf = lu;
      sd = lu && !s.pcSrcE;
      fd = s.pcSrcE;
      fe = lu || s.pcSrcE;
    end
    e = {err_now, sf, sd, se, sm, fd, fe, fwd(s, s.rs1E), fwd(s, s.rs2E)};
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s, input string tag);
    logic [10:0] e;
    @(posedge clk);
    #1;
    rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
    RdE = s.RdE; regWriteE = s.regWriteE; resultSrcE = s.resultSrcE;
    RdM = s.RdM; regWriteM = s.regWriteM; RdestW = s.RdestW; regWriteWB = s.regWriteWB;
    pcSrcE = s.pcSrcE; memReqM = s.memReqM; memAckM = s.memAckM;
    model_step(s, e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: the controller presents a full decision every cycle; sample it mid-cycle.
  initial begin
    logic [10:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {21'd0, memErr, stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE},
              {21'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    // Reset with busy-looking inputs must still show quiet outputs.
    for (int i = 0; i < 3; i++) begin
      s = stim_t'({$urandom, $urandom});
      s.rst = 1'b0;
      apply(s, "reset");
    end

    s = idle(); s.regWriteM = 1; s.RdM = 3; s.regWriteWB = 1; s.RdestW = 3; s.rs1E = 3; s.rs2E = 5;
    apply(s, "fwd_prio");
    s.RdM = 4;
    apply(s, "fwd_wb");

    s = idle(); s.regWriteM = 1; s.RdM = 0; s.rs1E = 0;
    apply(s, "r0_fwd");
    s.regWriteE = 1; s.resultSrcE = 2'b01; s.RdE = 0; s.rs1D = 0;
    apply(s, "r0_load");

    s = idle(); s.regWriteE = 1; s.resultSrcE = 2'b01; s.RdE = 2; s.rs2D = 2; s.rs1D = 9;
    apply(s, "load_use");
    s.RdE = 7;
    apply(s, "load_use_clear");

    s = idle(); s.pcSrcE = 1;
    apply(s, "branch_flush");

    s = idle(); s.pcSrcE = 1; s.memReqM = 1;
    for (int i = 0; i < 3; i++) apply(s, "mem_wait_branch");
    s.memAckM = 1;
    apply(s, "mem_ack_release");
    s.memReqM = 0; s.memAckM = 0;
    apply(s, "branch_after_wait");

    s = idle(); s.memReqM = 1;
    for (int i = 0; i < 8; i++) apply(s, "mem_timeout");
    s.rst = 1'b0;
    apply(s, "reset_mid_wait");
    s = idle();
    apply(s, "after_reset");

    for (int i = 0; i < 400; i++) begin
      s.rst        = ($urandom_range(63) != 0);
      s.rs1D       = 4'($urandom_range(3));
      s.rs2D       = 4'($urandom_range(3));
      s.rs1E       = 4'($urandom_range(3));
      s.rs2E       = 4'($urandom_range(3));
      s.RdE        = 4'($urandom_range(3));
      s.RdM        = 4'($urandom_range(3));
      s.RdestW     = 4'($urandom_range(3));
      s.regWriteE  = 1'($urandom);
      s.regWriteM  = 1'($urandom);
      s.regWriteWB = 1'($urandom);
      s.resultSrcE = 2'($urandom);
      s.pcSrcE     = ($urandom_range(4) == 0);
      s.memReqM    = ($urandom_range(3) == 0);
      s.memAckM    = ($urandom_range(2) == 0);
      apply(s, "random");
    end

    for (int i = 0; i < 3; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 16-bit, 5-stage pipeline (fetch, decode, execute, memory, writeback).
- Generates the execute-stage operand forwarding selects.
- Detects load-use hazards against the decode stage.
- Flushes decode and execute on a taken branch or jump.
- Freezes the whole pipe while a data-memory access waits for its acknowledge, with a timeout guard.
- Sits beside the decode/execute pipeline registers and drives their stall/flush enables.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before abort; legal range 1..255.
R0_ZERO, 1, when 1, register 0 is hard-wired zero and never forwarded or hazard-matched.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
rs1D  in  4  source register 1 of instruction in decode
rs2D  in  4  source register 2 of instruction in decode
rs1E  in  4  source register 1 in execute
rs2E  in  4  source register 2 in execute
RdE  in  4  destination register in execute
regWriteE  in  1  execute instruction writes the register file
resultSrcE  in  2  result select in execute; 2'b01 = load
RdM  in  4  destination in memory stage
regWriteM  in  1  memory-stage instruction writes the register file
RdestW  in  4  destination in writeback
regWriteWB  in  1  writeback write enable
pcSrcE  in  1  taken branch or jump resolved in execute
memReqM  in  1  memory stage issues a data-memory access this cycle
memAckM  in  1  data memory completes the access
stallF  out  1  hold PC
stallD  out  1  hold the fetch/decode register
stallE  out  1  hold the decode/execute register
stallM  out  1  hold the execute/memory register
flushD  out  1  clear the fetch/decode register
flushE  out  1  clear the decode/execute register
forwardAE  out  2  operand A select: 00 = register file, 01 = writeback result, 10 = memory-stage ALU result
forwardBE  out  2  operand B select, same encoding as forwardAE
memErr  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst low, asynchronous):
  - state=RUN; wait counter=0; memErr=0.
  - All stall and flush outputs are 0; forwardAE and forwardBE are 2'b00.
- Forwarding (combinational, all states), forwardAE:
  - 10 if regWriteM && RdM==rs1E && !(R0_ZERO && RdM==0).
  - Otherwise 01 if regWriteWB && RdestW==rs1E && !(R0_ZERO && RdestW==0).
  - Otherwise 00. The memory-stage match wins when both match.
  - forwardBE is identical, using rs2E.
- loadUse = regWriteE && resultSrcE==2'b01 && (RdE==rs1D || RdE==rs2D) && !(R0_ZERO && RdE==0).
- States: RUN, MEM_WAIT. State is 1 register; the wait counter is 8 bits.
- RUN, outputs:
  - If memReqM && !memAckM: stallF=stallD=stallE=stallM=1, flushD=flushE=0.
  - Otherwise, if loadUse: stallF=stallD=1, flushE=1.
  - In addition, if pcSrcE: flushD=1, flushE=1.
  - A flush from pcSrcE overrides stallD for the fetch/decode register.
- RUN, transitions:
  - memReqM && !memAckM: go to MEM_WAIT, counter=1.
  - memReqM && memAckM in the same cycle: stay in RUN, no stall (zero-wait access).
- MEM_WAIT:
  - stallF=stallD=stallE=stallM=1; flushD=flushE=0. pcSrcE and loadUse are ignored; they stay held by the stall and are re-evaluated in the first RUN cycle.
  - memAckM=1: go to RUN next cycle, counter cleared. The release cycle itself still stalls.
  - Otherwise, counter==MEM_TIMEOUT: memErr<=1, go to RUN, counter cleared.
  - Otherwise, counter increments.
- memErr stays set until reset.
- Mid-operation reset: MEM_WAIT aborts immediately; all outputs drop to their reset values asynchronously.
- Wait-counter width is 8 bits; with MEM_TIMEOUT ≤ 255 it never wraps.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Adds outputs perfStallCnt[15:0] and perfFlushCnt[15:0], both reset to 0 and saturating at 16'hFFFF.
  - perfStallCnt increments on every cycle with stallF=1.
  - perfFlushCnt increments on every cycle with flushE=1.
- HAZ_PERF_CNT_EN undefined: ports and counters absent; all other behaviour unchanged.

Test Plan:
- Forwarding priority:
  - Stimulus: regWriteM=1, RdM=3, regWriteWB=1, RdestW=3, rs1E=3, rs2E=5.
  - Response: forwardAE=10, forwardBE=00.
  - Then set RdM=4: forwardAE=01.
- R0 protection: R0_ZERO=1, regWriteM=1, RdM=0, rs1E=0 -> forwardAE=00. The same stimulus with a load RdE=0, rs1D=0 -> no stall.
- Load-use:
  - Stimulus: regWriteE=1, resultSrcE=01, RdE=2, rs2D=2 for one cycle.
  - Response: stallF=stallD=flushE=1 in that cycle only; all 0 the next cycle after RdE changes.
- Branch flush: pcSrcE=1 in RUN with no hazard -> flushD=flushE=1, all stalls 0.
- Memory wait with a pending branch:
  - Stimulus: memReqM=1, memAckM=0 for 3 cycles, then memAckM=1, with pcSrcE=1 held throughout.
  - Response: all four stalls high through the ack cycle and no flush during MEM_WAIT; flushD=flushE=1 in the first RUN cycle.
- Timeout and reset: MEM_TIMEOUT=4, memReqM=1, memAckM never asserted -> memErr=1 after 4 MEM_WAIT cycles, state returns to RUN. Pulling rst low mid-wait clears memErr and all stalls immediately.
